// File: rtl/ss_retire_pkg.sv
// Shared types and sizing for the superscalar retire stage.
// Physical register 0 is the hard-wired zero register and is never returned to the free list.
package ss_retire_pkg;

    localparam int PRF_SIZE = 64;
    localparam int ROB_SIZE = 32;
    localparam int ARF_SIZE = 32;

    localparam int PREG_W = $clog2(PRF_SIZE);
    localparam int ROB_W  = $clog2(ROB_SIZE);
    localparam int AREG_W = $clog2(ARF_SIZE);

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [ROB_W-1:0]  rob_idx_t;
    typedef logic [AREG_W-1:0] areg_t;

    localparam preg_t ZERO_PREG = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        ROLLBACK = 2'd1,
        FLUSH    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    typedef struct packed {
        preg_t told;
        preg_t tnew;
        areg_t areg;
        logic  has_dest;
    } retire_packet_t;

    // ROB indices wrap naturally through ROB_W-bit truncation.
    function automatic rob_idx_t rob_add(input rob_idx_t base, input rob_idx_t off);
        return base + off;
    endfunction

endpackage

// File: rtl/ss_retire_if.sv
// ROB-head view seen by the retire stage: the oldest WIDTH entries plus the pop mask back to the ROB.
interface ss_retire_if #(
    parameter int WIDTH = 2
);
    import ss_retire_pkg::*;

    logic [WIDTH-1:0]  head_valid;
    logic [WIDTH-1:0]  head_complete;
    logic [WIDTH-1:0]  head_mispredict;
    logic [WIDTH-1:0]  head_halt;
    logic [WIDTH-1:0]  head_has_dest;
    preg_t [WIDTH-1:0] head_told;
    preg_t [WIDTH-1:0] head_tnew;
    areg_t [WIDTH-1:0] head_areg;
    rob_idx_t          head_idx;
    logic [WIDTH-1:0]  rob_pop;

    modport master (
        output head_valid, head_complete, head_mispredict, head_halt, head_has_dest,
        output head_told, head_tnew, head_areg, head_idx,
        input  rob_pop
    );

    modport slave (
        input  head_valid, head_complete, head_mispredict, head_halt, head_has_dest,
        input  head_told, head_tnew, head_areg, head_idx,
        output rob_pop
    );

endinterface

// File: rtl/ss_retire_select.sv
// Combinational in-order prefix picker: pops the oldest run of complete entries,
// closing the group on the first mispredict or halt it retires.
module ss_retire_select #(
    parameter  int WIDTH  = 2,
    localparam int SLOT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic              enable,
    input  logic [WIDTH-1:0]  valid,
    input  logic [WIDTH-1:0]  complete,
    input  logic [WIDTH-1:0]  mispredict,
    input  logic [WIDTH-1:0]  halt,
    output logic [WIDTH-1:0]  pop,
    output logic              redirect,
    output logic              stop,
    output logic [SLOT_W-1:0] redirect_slot
);

    // alive[i]: every older slot retired and none of them closed the group
    logic [WIDTH-1:0] alive;

    assign alive[0] = enable;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slot
            assign pop[gi] = alive[gi] & valid[gi] & complete[gi];
            if (gi < WIDTH - 1) begin : g_chain
                assign alive[gi+1] = pop[gi] & ~mispredict[gi] & ~halt[gi];
            end
        end
    endgenerate

    assign redirect = |(pop & mispredict);
    assign stop     = |(pop & halt);

    // At most one popped slot can be a mispredict, so a plain scan is an exact encoder.
    always_comb begin
        redirect_slot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pop[i] && mispredict[i]) begin
                redirect_slot = SLOT_W'(i);
            end
        end
    end

endmodule

// File: rtl/ss_retire.sv
// Retire stage: pops the retirable ROB prefix, returns Told / commits Tnew one cycle later,
// and sequences rollback + flush on a mispredicted branch or stops on a halt.
module ss_retire
    import ss_retire_pkg::*;
#(
    parameter int WIDTH        = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    ss_retire_if.slave        head,
    output logic [WIDTH-1:0]  retire_en,
    output preg_t [WIDTH-1:0] retire_reg,
    output logic [WIDTH-1:0]  arch_we,
    output areg_t [WIDTH-1:0] arch_areg,
    output preg_t [WIDTH-1:0] arch_preg,
    output logic              rollback_en,
    output rob_idx_t          rewind_head,
    output logic              flushing,
    output logic              halted,
    output logic [63:0]       retired_count
);

    localparam int SLOT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   flush_cnt_reg, flush_cnt_next;
    logic               rollback_en_reg;
    rob_idx_t           rewind_head_reg;
    logic [63:0]        retired_count_reg;
    logic [63:0]        pop_count;

    logic [WIDTH-1:0]   pop;
    logic               redirect;
    logic               stop;
    logic [SLOT_W-1:0]  redirect_slot;

    // Reset is active-low; nothing may pop while it is held.
    ss_retire_select #(
        .WIDTH (WIDTH)
    ) u_select (
        .enable        (reset && (state_reg == RUN)),
        .valid         (head.head_valid),
        .complete      (head.head_complete),
        .mispredict    (head.head_mispredict),
        .halt          (head.head_halt),
        .pop           (pop),
        .redirect      (redirect),
        .stop          (stop),
        .redirect_slot (redirect_slot)
    );

    assign head.rob_pop = pop;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= RUN;
            flush_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        unique case (state_reg)
            RUN: begin
                if (redirect) begin
                    state_next = ROLLBACK;
                end else if (stop) begin
                    state_next = HALTED;
                end
            end
            ROLLBACK: begin
                state_next     = FLUSH;
                flush_cnt_next = CNT_W'(FLUSH_CYCLES - 1);
            end
            FLUSH: begin
                if (flush_cnt_reg == '0) begin
                    state_next = RUN;
                end else begin
                    flush_cnt_next = flush_cnt_reg - 1'b1;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign flushing = (state_reg == ROLLBACK) || (state_reg == FLUSH);
    assign halted   = (state_reg == HALTED);

    // Per-slot registered free-list return and architectural commit.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_out
            retire_packet_t pkt;
            logic  free_next, we_next;
            logic  en_reg, we_reg;
            preg_t rreg_reg, preg_reg;
            areg_t areg_reg;

            assign pkt = '{told:     head.head_told[gi],
                           tnew:     head.head_tnew[gi],
                           areg:     head.head_areg[gi],
                           has_dest: head.head_has_dest[gi]};

            assign we_next   = pop[gi] & pkt.has_dest;
            assign free_next = we_next & (pkt.told != ZERO_PREG);

            always_ff @(posedge clock) begin
                if (!reset) begin
                    en_reg   <= 1'b0;
                    rreg_reg <= ZERO_PREG;
                    we_reg   <= 1'b0;
                    areg_reg <= '0;
                    preg_reg <= ZERO_PREG;
                end else begin
                    en_reg   <= free_next;
                    rreg_reg <= free_next ? pkt.told : ZERO_PREG;
                    we_reg   <= we_next;
                    areg_reg <= we_next ? pkt.areg : '0;
                    preg_reg <= we_next ? pkt.tnew : ZERO_PREG;
                end
            end

            assign retire_en[gi]  = en_reg;
            assign retire_reg[gi] = rreg_reg;
            assign arch_we[gi]    = we_reg;
            assign arch_areg[gi]  = areg_reg;
            assign arch_preg[gi]  = preg_reg;
        end
    endgenerate

    always_comb begin
        pop_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_count = pop_count + 64'(pop[i]);
        end
    end

    // The rollback pulse lines up with the branch group's registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rollback_en_reg   <= 1'b0;
            rewind_head_reg   <= '0;
            retired_count_reg <= '0;
        end else begin
            rollback_en_reg   <= redirect;
            if (redirect) begin
                rewind_head_reg <= rob_add(head.head_idx, rob_idx_t'(redirect_slot));
            end
            retired_count_reg <= retired_count_reg + pop_count;
        end
    end

    assign rollback_en   = rollback_en_reg;
    assign rewind_head   = rewind_head_reg;
    assign retired_count = retired_count_reg;

endmodule
